// File: rtl/Fragmentation_Package.sv
// ============================================================================
// Fragmentation_Package
// ----------------------------------------------------------------------------
// Shared constants and types for the TL_TX Data_Fragmentation ECRC path.
//
// Contents:
//   DATA_ECRC_IN_WIDTH  - message beat width fed to the ECRC engine (bits)
//   ECRC_LENGTH_WIDTH   - width of the per-beat byte count
//   POLY_WIDTH          - CRC width
//   ECRC_SEED           - seed loaded into the engine at the start of a TLP
//   VARIANT_BIT_TYPE0   - Type[0] position, as a bit offset from the beat MSB
//   VARIANT_BIT_EP      - EP position, as a bit offset from the beat MSB
//   ecrc_ctrl_state_e   - sequencer states
//
// Optional feature macro used by the consumers of this package:
//   ECRC_VARIANT_MASK_EN
// ============================================================================
package Fragmentation_Package;

    localparam int DATA_ECRC_IN_WIDTH = 256;
    localparam int ECRC_LENGTH_WIDTH  = 6;
    localparam int POLY_WIDTH         = 32;

    localparam logic [31:0] ECRC_SEED = 32'hFFFF_FFFF;

    // Byte 0 sits at the MSBs of a beat. Offsets are counted down from the
    // MSB so they stay valid for any beat width:
    //   Type[0] = byte 0 bit 0 -> offset 7
    //   EP      = byte 2 bit 6 -> offset 2*8 + (7-6) = 17
    localparam int VARIANT_BIT_TYPE0 = 7;
    localparam int VARIANT_BIT_EP    = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,   // no TLP open
        ACCUM  = 3'd1,   // TD=1 TLP open, engine accumulating
        BYPASS = 3'd2,   // TD=0 TLP open, engine untouched
        WAIT   = 3'd3,   // engine result settling
        HOLD   = 3'd4    // ECRC presented to the consumer
    } ecrc_ctrl_state_e;

endpackage

// File: rtl/ecrc_variant_mask.sv
// ============================================================================
// ecrc_variant_mask
// ----------------------------------------------------------------------------
// Combinational masker that forces the PCIe variant bits (Type[0] and EP) to
// 1 on the SOP beat before it reaches the ECRC engine. Non-SOP beats pass
// unchanged.
//
// Ports:
//   msg_in   in  DATA_WIDTH  beat, byte 0 at the MSBs
//   sop      in  1           beat is the first of a TLP
//   msg_out  out DATA_WIDTH  beat with variant bits forced on SOP
//
// Only instantiated when ECRC_VARIANT_MASK_EN is defined.
// ============================================================================
module ecrc_variant_mask
    import Fragmentation_Package::*;
#(
    parameter int DATA_WIDTH = DATA_ECRC_IN_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] msg_in,
    input  logic                  sop,
    output logic [DATA_WIDTH-1:0] msg_out
);

    localparam int POS_TYPE0 = DATA_WIDTH - 1 - VARIANT_BIT_TYPE0;
    localparam int POS_EP    = DATA_WIDTH - 1 - VARIANT_BIT_EP;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            if ((gi == POS_TYPE0) || (gi == POS_EP)) begin : g_variant
                assign msg_out[gi] = msg_in[gi] | sop;
            end else begin : g_pass
                assign msg_out[gi] = msg_in[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/ecrc_ctrl.sv
// ============================================================================
// ecrc_ctrl
// ----------------------------------------------------------------------------
// Sequences the ECRC engine inside TL_TX Data_Fragmentation. SOP/EOP framed
// TLP beats are accepted from the fragmentation arbiter path; TD=1 TLPs are
// streamed into the engine (seed + accumulate), the finished ECRC is captured
// and held on a valid/ready handshake until the fragmentation logic appends
// it. TD=0 TLPs pass through without engine activity.
//
// Ports:
//   clk              in   clock
//   arst             in   asynchronous reset, active-low
//   tlp_i_valid      in   beat valid
//   tlp_o_ready      out  beat accepted when valid & ready
//   tlp_i_data       in   beat data, byte 0 at MSBs
//   tlp_i_bytes      in   valid bytes in beat (MSB-aligned)
//   tlp_i_sop/eop    in   TLP framing
//   tlp_i_td         in   ECRC requested, sampled on SOP
//   CRC_i_Message    out  } engine drive: the ecrc_if arbiter_ecrc
//   CRC_i_Length     out  } signal set (message, length, enable,
//   CRC_i_EN         out  } seed and seed-load)
//   CRC_i_Seed       out  }
//   CRC_i_Seed_Load  out  }
//   CRC_o_CRC        in   engine result, valid the cycle after an EN
//   ecrc_o_valid     out  ECRC available
//   ecrc_o_value     out  final ECRC
//   ecrc_i_ready     in   consumer takes ECRC
//   busy_o           out  state != IDLE
//   err_o            out  one-cycle protocol-error pulse (beat still consumed)
//
// Optional feature macro: ECRC_VARIANT_MASK_EN
//   Defined   : SOP beat has Type[0] and EP forced to 1 on CRC_i_Message.
//   Undefined : CRC_i_Message is tlp_i_data unmodified.
// ============================================================================
module ecrc_ctrl #(
    parameter int                DATA_WIDTH = Fragmentation_Package::DATA_ECRC_IN_WIDTH,
    parameter int                LEN_WIDTH  = Fragmentation_Package::ECRC_LENGTH_WIDTH,
    parameter int                POLY_WIDTH = Fragmentation_Package::POLY_WIDTH,
    parameter logic [POLY_WIDTH-1:0] ECRC_SEED = Fragmentation_Package::ECRC_SEED
) (
    input  logic                  clk,
    input  logic                  arst,

    input  logic                  tlp_i_valid,
    output logic                  tlp_o_ready,
    input  logic [DATA_WIDTH-1:0] tlp_i_data,
    input  logic [LEN_WIDTH-1:0]  tlp_i_bytes,
    input  logic                  tlp_i_sop,
    input  logic                  tlp_i_eop,
    input  logic                  tlp_i_td,

    output logic [DATA_WIDTH-1:0] CRC_i_Message,
    output logic [LEN_WIDTH-1:0]  CRC_i_Length,
    output logic                  CRC_i_EN,
    output logic [POLY_WIDTH-1:0] CRC_i_Seed,
    output logic                  CRC_i_Seed_Load,
    input  logic [POLY_WIDTH-1:0] CRC_o_CRC,

    output logic                  ecrc_o_valid,
    output logic [POLY_WIDTH-1:0] ecrc_o_value,
    input  logic                  ecrc_i_ready,

    output logic                  busy_o,
    output logic                  err_o
);

    import Fragmentation_Package::*;

    localparam int                   MAX_BYTES = DATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_BYTES);

    ecrc_ctrl_state_e        state_reg;
    ecrc_ctrl_state_e        state_next;
    logic [POLY_WIDTH-1:0]   ecrc_value_reg;

    logic                    open_state;    // states that take beats
    logic                    beat_ready;
    logic                    accept;
    logic                    sop_accept;
    logic                    seed_load;
    logic                    engine_en;
    logic                    bad_len;
    logic [LEN_WIDTH-1:0]    len_clamped;
    logic                    err_orphan;    // non-SOP beat with no TLP open
    logic                    err_abort;     // SOP while a TLP is still open
    logic [DATA_WIDTH-1:0]   message;

    // ------------------------------------------------------------------------
    // State and captured ECRC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_reg      <= IDLE;
            ecrc_value_reg <= '0;
        end else begin
            state_reg <= state_next;
            // The engine result is valid exactly one cycle after the last EN,
            // which is the single WAIT cycle.
            if (state_reg == WAIT) begin
                ecrc_value_reg <= CRC_o_CRC;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Beat acceptance and engine strobes
    // ------------------------------------------------------------------------
    always_comb begin
        open_state  = (state_reg == IDLE) || (state_reg == ACCUM) ||
                      (state_reg == BYPASS);
        // Outputs are held low while reset is asserted, so ready is also
        // qualified with arst even though the state already reads IDLE.
        beat_ready  = arst && open_state;
        accept      = tlp_i_valid && beat_ready;
        sop_accept  = accept && tlp_i_sop;

        // Any SOP (normal, or one that aborts an open TLP) restarts the
        // engine from the seed. Seed and first accumulate share a cycle.
        seed_load   = sop_accept && tlp_i_td;
        engine_en   = seed_load ||
                      (accept && !tlp_i_sop && (state_reg == ACCUM));

        bad_len     = (tlp_i_bytes == '0) || (tlp_i_bytes > MAX_LEN);
        len_clamped = bad_len ? MAX_LEN : tlp_i_bytes;

        err_orphan  = (state_reg == IDLE) && !tlp_i_sop;
        err_abort   = tlp_i_sop &&
                      ((state_reg == ACCUM) || (state_reg == BYPASS));
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM, BYPASS: begin
                if (sop_accept) begin
                    if (tlp_i_td) begin
                        state_next = tlp_i_eop ? WAIT : ACCUM;
                    end else begin
                        state_next = tlp_i_eop ? IDLE : BYPASS;
                    end
                end else if (accept && tlp_i_eop) begin
                    // A stray EOP in IDLE is dropped with the rest of the
                    // orphan beat; IDLE keeps its value.
                    if (state_reg == ACCUM) begin
                        state_next = WAIT;
                    end else if (state_reg == BYPASS) begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (ecrc_i_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Engine message path
    // ------------------------------------------------------------------------
`ifdef ECRC_VARIANT_MASK_EN
    ecrc_variant_mask #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_variant_mask (
        .msg_in  (tlp_i_data),
        .sop     (tlp_i_sop),
        .msg_out (message)
    );
`else
    assign message = tlp_i_data;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tlp_o_ready     = beat_ready;
    assign CRC_i_EN        = engine_en;
    assign CRC_i_Seed_Load = seed_load;
    assign CRC_i_Seed      = ECRC_SEED;
    assign CRC_i_Message   = arst ? message     : '0;
    assign CRC_i_Length    = arst ? len_clamped : '0;

    assign ecrc_o_valid    = (state_reg == HOLD);
    assign ecrc_o_value    = ecrc_value_reg;
    assign busy_o          = (state_reg != IDLE);
    assign err_o           = accept && (err_orphan || err_abort || bad_len);

endmodule
